// File: rtl/dcache_controller.sv
// dcache_controller
// Sequences hits, write-backs and refills for a 2-way set-associative data
// cache. There are 16 sets of 256-bit lines. Each tag word is
// {valid, dirty, tag[22:0]}.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | serve hits in the request cycle; a miss moves to MISS
// MISS        | capture the victim and issue write-back or refill read
// WRITEBACK   | dirty victim line going out to memory; wait for ack
// REFILL      | refill read outstanding; ack writes the line into SRAM
// REFILL_DONE | one settle cycle before the request replays as a hit
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    REFILL,
    REFILL_DONE
  } state_t;

  state_t         state;
  logic [2:0]     word_sel;
  logic [255:0]   store_line;
  logic           store_hit;
  logic           refill_wr;
  logic           unused_addr_bits;

  assign word_sel         = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // Hit line with the addressed word replaced by the store data
  always_comb begin
    store_line = sram_data_i;
    store_line[32*word_sel +: 32] = cpu_data_i;
  end

  assign store_hit = (state == IDLE) && cpu_req_i && sram_hit_i && cpu_write_i;
  assign refill_wr = (state == REFILL) && mem_ack_i;

  // CPU-side and SRAM-side outputs are combinational. Writes are gated by
  // reset, so an aborted sequence never leaves a partial line behind.
  always_comb begin
    cpu_data_o    = sram_data_i[32*word_sel +: 32];
    cpu_stall_o   = (state != IDLE) || (cpu_req_i && !sram_hit_i);
    sram_addr_o   = cpu_addr_i[8:5];
    sram_tag_o    = {1'b1, (state == IDLE), cpu_addr_i[31:9]};
    sram_data_o   = (state == REFILL) ? mem_data_i : store_line;
    sram_enable_o = !rst_i && (store_hit || refill_wr);
    sram_write_o  = !rst_i && (store_hit || refill_wr);
  end

  // Miss sequencer. The memory request is registered and holds until ack.
  // mem_data_o keeps the captured victim line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i && !sram_hit_i) state <= MISS;
        end
        MISS: begin
          mem_enable_o <= 1'b1;
          mem_data_o   <= sram_data_i;
          if (sram_tag_i[24] && sram_tag_i[23]) begin
            state       <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {sram_tag_i[22:0], cpu_addr_i[8:5], 5'b0};
          end else begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {cpu_addr_i[31:5], 5'b0};
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {cpu_addr_i[31:5], 5'b0};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state        <= REFILL_DONE;
            mem_enable_o <= 1'b0;
          end
        end
        REFILL_DONE: state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller
// Uses a behavioural SRAM and memory environment plus a line-level cache
// reference model. Expected SRAM writes, memory requests and load data are
// queued when each access is issued. A monitor checks them as the DUT
// produces them.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
    .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
    .sram_write_o(sram_write_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Initial memory contents, shared as a constant table by environment and model
  function automatic logic [255:0] init_line(input logic [26:0] la);
    logic [255:0] l;
    logic [31:0]  t;
    for (int k = 0; k < 8; k++) begin
      t = {k[4:0], la};
      l[32*k +: 32] = t * 32'h9E37_79B9 + 32'h1234_5678;
    end
    return l;
  endfunction

  // ---------------- environment: cache SRAM (2 ways, true LRU) ----------------
  logic [24:0]  env_tag [16][2] = '{default: '0};
  logic [255:0] env_dat [16][2] = '{default: '0};
  logic         env_lru [16]    = '{default: 1'b0};
  logic [255:0] env_mem [logic [26:0]];
  logic [3:0]   e_idx;
  logic         e_h0, e_h1, e_way;

  always_comb begin
    e_idx = cpu_addr_i[8:5];
    e_h0  = env_tag[e_idx][0][24] && (env_tag[e_idx][0][22:0] == cpu_addr_i[31:9]);
    e_h1  = env_tag[e_idx][1][24] && (env_tag[e_idx][1][22:0] == cpu_addr_i[31:9]);
    sram_hit_i = e_h0 || e_h1;
    e_way = e_h0 ? 1'b0 : (e_h1 ? 1'b1 : env_lru[e_idx]);
    sram_tag_i  = env_tag[e_idx][e_way];
    sram_data_i = env_dat[e_idx][e_way];
  end

  logic         pend_wr = 1'b0, pend_lru = 1'b0, pend_way = 1'b0;
  logic [3:0]   pend_idx = '0;
  logic [24:0]  pend_tag = '0;
  logic [255:0] pend_dat = '0;

  always @(posedge clk_i) begin
    if (pend_wr) begin
      env_tag[pend_idx][pend_way] <= pend_tag;
      env_dat[pend_idx][pend_way] <= pend_dat;
      env_lru[pend_idx]           <= ~pend_way;
    end else if (pend_lru) begin
      env_lru[pend_idx] <= ~pend_way;
    end
  end

  // ---------------- environment: line memory responder ----------------
  int lat_fixed = 0;
  int spur_cnt  = 0;

  initial begin
    int cnt = 0, cur_lat = 1, spur_seen = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
        continue;
      end
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end else if (spur_seen != spur_cnt) begin
        spur_seen = spur_cnt;
        mem_ack_i = 1'b1;
        mem_data_i = {8{$urandom()}};
        continue;
      end
      if (mem_enable_o) begin
        if (cnt == 0) cur_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
        cnt++;
        if (cnt == cur_lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) env_mem[mem_addr_o[31:5]] = mem_data_o;
          else mem_data_i = env_mem.exists(mem_addr_o[31:5]) ? env_mem[mem_addr_o[31:5]]
                                                              : init_line(mem_addr_o[31:5]);
        end
      end
    end
  end

  // ---------------- reference model and scoreboard queues ----------------
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } mem_t;
  typedef struct { logic [3:0] idx; logic [24:0] tag; logic [255:0] data; } sram_t;
  mem_t         mem_q[$];
  sram_t        sram_q[$];
  logic [31:0]  load_q[$];

  logic [26:0]  rset [16][$];
  logic [255:0] rline [logic [26:0]];
  bit           rdirty [logic [26:0]];
  logic [255:0] rmem [logic [26:0]];

  task automatic predict(input bit w, input logic [31:0] a, input logic [31:0] d, output bit hit);
    logic [26:0]  la = a[31:5];
    logic [3:0]   idx = a[8:5];
    logic [2:0]   wd = a[4:2];
    logic [26:0]  v;
    logic [255:0] line;
    mem_t         m;
    sram_t        s;
    int           pos = -1;
    for (int i = 0; i < rset[idx].size(); i++) if (rset[idx][i] == la) pos = i;
    hit = (pos >= 0);
    if (hit) begin
      rset[idx].delete(pos);
      rset[idx].push_back(la);
    end else begin
      if (rset[idx].size() == 2) begin
        v = rset[idx].pop_front();
        if (rdirty[v]) begin
          m.wr = 1'b1; m.addr = {v, 5'b0}; m.data = rline[v];
          mem_q.push_back(m);
          rmem[v] = rline[v];
        end
        rline.delete(v);
        rdirty.delete(v);
      end
      m.wr = 1'b0; m.addr = {la, 5'b0}; m.data = '0;
      mem_q.push_back(m);
      line = rmem.exists(la) ? rmem[la] : init_line(la);
      rline[la] = line;
      rdirty[la] = 1'b0;
      s.idx = idx; s.tag = {2'b10, a[31:9]}; s.data = line;
      sram_q.push_back(s);
      rset[idx].push_back(la);
    end
    line = rline[la];
    if (w) begin
      line[32*wd +: 32] = d;
      rline[la] = line;
      rdirty[la] = 1'b1;
      s.idx = idx; s.tag = {2'b11, a[31:9]}; s.data = line;
      sram_q.push_back(s);
    end else begin
      load_q.push_back(line[32*wd +: 32]);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit          prev_en = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = '0;
    sram_t       s;
    mem_t        m;
    forever begin
      @(negedge clk_i);
      #3;
      pend_wr  = 1'b0;
      pend_lru = 1'b0;
      if (rst_i) begin
        prev_en = 1'b0;
        continue;
      end
      if (sram_enable_o && sram_write_o) begin
        if (sram_q.size() == 0) begin
          chk("sram_write_unexpected", 1'b1, 1'b0);
        end else begin
          s = sram_q.pop_front();
          chk("sram_addr", sram_addr_o, s.idx);
          chk("sram_tag", sram_tag_o, s.tag);
          chk("sram_data", sram_data_o, s.data);
        end
        pend_wr = 1'b1; pend_idx = e_idx; pend_way = e_way;
        pend_tag = sram_tag_o; pend_dat = sram_data_o;
      end else if (cpu_req_i && sram_hit_i && !cpu_stall_o && !cpu_write_i) begin
        pend_lru = 1'b1; pend_idx = e_idx; pend_way = e_way;
      end
      if (cpu_req_i && !cpu_stall_o && !cpu_write_i) begin
        if (load_q.size() == 0) chk("load_unexpected", 1'b1, 1'b0);
        else chk("load_data", cpu_data_o, load_q.pop_front());
      end
      if (mem_enable_o && (!prev_en || prev_wr != mem_write_o || prev_addr != mem_addr_o)) begin
        if (mem_q.size() == 0) begin
          chk("mem_req_unexpected", 1'b1, 1'b0);
        end else begin
          m = mem_q.pop_front();
          chk("mem_write", mem_write_o, m.wr);
          chk("mem_addr", mem_addr_o, m.addr);
          if (m.wr) chk("mem_wb_data", mem_data_o, m.data);
        end
      end
      prev_en = mem_enable_o; prev_wr = mem_write_o; prev_addr = mem_addr_o;
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d, input int exp_stall);
    bit hit;
    int stalls = 0;
    predict(w, a, d, hit);
    cpu_req_i = 1'b1; cpu_write_i = w; cpu_addr_i = a; cpu_data_i = d;
    forever begin
      @(negedge clk_i);
      #3;
      if (!cpu_stall_o) break;
      stalls++;
      if (stalls > 300) begin
        chk("op_timeout", 1'b1, 1'b0);
        break;
      end
    end
    if (exp_stall >= 0) chk("stall_cycles", stalls, exp_stall);
    else chk("hit_no_stall", (stalls == 0), hit);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    mem_t m;
    int   guard;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    #3;
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_sram_en", sram_enable_o, 1'b0);
    chk("rst_sram_wr", sram_write_o, 1'b0);
    chk("rst_mem_en", mem_enable_o, 1'b0);
    chk("rst_mem_wr", mem_write_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 256'h0);
    @(posedge clk_i);
    #1;

    // Clean miss into an empty set, then store hit, then a dirty eviction
    lat_fixed = 10;
    do_op(1'b0, 32'h0000_0040, 32'h0, 13);
    lat_fixed = 0;
    do_op(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0);
    lat_fixed = 4;
    do_op(1'b0, 32'h0000_0240, 32'h0, 7);
    do_op(1'b0, 32'h0000_0440, 32'h0, 11);
    do_op(1'b0, 32'h0000_0640, 32'h0, 7);

    // Reset while a refill is outstanding
    lat_fixed = 50;
    m.wr = 1'b0; m.addr = 32'h0000_A1E0; m.data = '0;
    mem_q.push_back(m);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_A1E0;
    guard = 0;
    while (!mem_enable_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    chk("abort_mem_en_seen", mem_enable_o, 1'b1);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_mem_en_async", mem_enable_o, 1'b0);
    chk("abort_sram_wr", sram_write_o, 1'b0);
    cpu_req_i = 1'b0;
    #1;
    chk("abort_stall", cpu_stall_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    lat_fixed = 0;

    // Spurious ack while idle
    spur_cnt++;
    guard = 0;
    do begin
      @(negedge clk_i);
      #3;
      guard++;
    end while (!mem_ack_i && guard < 10);
    chk("spur_ack_seen", mem_ack_i, 1'b1);
    chk("spur_sram_wr", sram_write_o, 1'b0);
    chk("spur_stall", cpu_stall_o, 1'b0);
    @(negedge clk_i);
    #3;
    chk("spur_mem_en", mem_enable_o, 1'b0);
    chk("spur_stall_after", cpu_stall_o, 1'b0);
    @(posedge clk_i);
    #1;

    // Random traffic over four sets with four tags each
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = {23'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 5) == 0) begin
        cpu_req_i = 1'b0; cpu_addr_i = a;
        @(negedge clk_i);
        #3;
        chk("gap_stall", cpu_stall_o, 1'b0);
        chk("gap_sram_wr", sram_enable_o, 1'b0);
        @(posedge clk_i);
        #1;
      end
      do_op(1'($urandom_range(0, 1)), a, $urandom(), -1);
    end
    cpu_req_i = 1'b0;
    repeat (5) @(posedge clk_i);
    chk("sram_q_drained", sram_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("load_q_drained", load_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
